// File: rtl/tc_responder_pkg.sv
// Shared definitions for the timer/counter responder: FSM encodings,
// register offsets, mode codes and the packed CTRL layout.
package tc_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'b00;
  localparam logic [1:0] OFF_PRESET = 2'b01;
  localparam logic [1:0] OFF_COUNT  = 2'b10;
  localparam logic [1:0] OFF_NONE   = 2'b11;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Bit order matches the software view: IM at bit 3, Mode at 2:1, Enable at 0.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       enable;
  } tc_ctrl_t;

  function automatic logic [31:0] ctrl_word(input tc_ctrl_t c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/tc_responder.sv
// Memory-mapped down-counter that raises an interrupt on expiry, with
// one-shot and auto-reload modes and a maskable IRQ output.
module tc_responder
  import tc_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  tc_state_e   state, state_next;
  tc_ctrl_t    ctrl, ctrl_next;
  logic [31:0] preset, preset_next;
  logic [31:0] count, count_next;
  logic        irq_flag, irq_flag_next;

  logic [1:0]  reg_sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        unused_addr;

  assign reg_sel     = Addr[3:2];
  assign wr_ctrl     = WE && (reg_sel == OFF_CTRL);
  assign wr_preset   = WE && (reg_sel == OFF_PRESET);
  assign unused_addr = ^Addr[31:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_next;
      ctrl     <= ctrl_next;
      preset   <= preset_next;
      count    <= count_next;
      irq_flag <= irq_flag_next;
    end
  end

  always_comb begin
    state_next    = state;
    ctrl_next     = ctrl;
    preset_next   = preset;
    count_next    = count;
    irq_flag_next = irq_flag;

    unique case (state)
      ST_IDLE: begin
        if (ctrl.enable) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        count_next = preset;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        // PRESET of 0 lands here with COUNT=0 and expires like PRESET=1.
        if (!ctrl.enable) begin
          state_next = ST_IDLE;
        end else if (count > 32'd1) begin
          count_next = count - 32'd1;
        end else begin
          count_next    = '0;
          irq_flag_next = 1'b1;
          state_next    = ST_INT;
        end
      end
      ST_INT: begin
        state_next = ST_IDLE;
        if (ctrl.mode == MODE_RELOAD) irq_flag_next = 1'b0;
        else                          ctrl_next.enable = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase

    // Software writes come last so they win over the FSM's own updates.
    if (wr_ctrl) begin
      ctrl_next     = tc_ctrl_t'(Din[3:0]);
      irq_flag_next = 1'b0;
    end
    if (wr_preset) begin
      preset_next   = Din;
      irq_flag_next = 1'b0;
    end
  end

  always_comb begin
    Dout = '0;
    case (reg_sel)
      OFF_CTRL:   Dout = ctrl_word(ctrl);
      OFF_PRESET: Dout = preset;
      OFF_COUNT:  Dout = count;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = ctrl.im & irq_flag;

endmodule

// File: tb/tb_tc_responder.sv
// Self-checking bench for tc_responder: a cycle model compared every
// negedge, plus directed sequences with hand-computed expectations.
module tb_tc_responder;

  localparam logic [1:0] T_CTRL   = 2'b00;
  localparam logic [1:0] T_PRESET = 2'b01;
  localparam logic [1:0] T_COUNT  = 2'b10;
  localparam logic [1:0] T_NONE   = 2'b11;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        WE    = 1'b0;
  logic [31:2] Addr  = '0;
  logic [31:0] Din   = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  tc_responder dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference behaviour: phase 0 waiting, 1 loading, 2 counting down, 3 expired.
  bit          m_valid = 1'b0;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  bit          m_flag;
  int          m_phase;
  logic [3:0]  n_ctrl;
  logic [31:0] n_preset, n_count;
  bit          n_flag;
  int          n_phase;

  always @(posedge clk) begin
    if (reset) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_phase = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
      n_flag = m_flag; n_phase = m_phase;
      if (m_phase == 0) begin
        if (m_ctrl[0]) n_phase = 1;
      end else if (m_phase == 1) begin
        n_count = m_preset;
        n_phase = 2;
      end else if (m_phase == 2) begin
        if (!m_ctrl[0]) n_phase = 0;
        else if (m_count >= 2) n_count = m_count - 1;
        else begin n_count = 0; n_flag = 1'b1; n_phase = 3; end
      end else begin
        n_phase = 0;
        if (m_ctrl[2:1] == 2'b01) n_flag = 1'b0;
        else n_ctrl[0] = 1'b0;
      end
      if (WE && Addr[3:2] == T_CTRL)   begin n_ctrl = Din[3:0]; n_flag = 1'b0; end
      if (WE && Addr[3:2] == T_PRESET) begin n_preset = Din;    n_flag = 1'b0; end
      m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
      m_flag = n_flag; m_phase = n_phase;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] off);
    case (off)
      T_CTRL:   return {28'd0, m_ctrl};
      T_PRESET: return m_preset;
      T_COUNT:  return m_count;
      default:  return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_dout", Dout, model_read(Addr[3:2]));
      checkOutput("model_irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
    end
  end

  // Drive one edge's worth of inputs, then drop the strobe just after the edge.
  task automatic applyStimulus(input logic we, input logic [1:0] off, input logic [31:0] d);
    Addr = {28'h00007F0, off};
    WE   = we;
    Din  = d;
    @(posedge clk);
    #1;
    WE  = 1'b0;
    Din = '0;
  endtask

  task automatic readAt(input logic [1:0] off);
    Addr = {28'h00007F0, off};
    #1;
  endtask

  task automatic idleTicks(input int n, input logic [1:0] off);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, off, 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, T_CTRL, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  int highs, first_hi, last_hi;
  logic [31:0] count8;
  bit irq_seen;

  initial begin
    reset = 1'b1;
    idleTicks(2, T_CTRL);
    reset = 1'b0;
    checkOutput("rst_irq", {31'd0, IRQ}, 32'd0);
    readAt(T_CTRL);   checkOutput("rst_ctrl", Dout, 32'd0);
    readAt(T_PRESET); checkOutput("rst_preset", Dout, 32'd0);
    readAt(T_COUNT);  checkOutput("rst_count", Dout, 32'd0);

    // One-shot countdown from 5 with IM set.
    applyStimulus(1'b1, T_PRESET, 32'd5);
    applyStimulus(1'b1, T_CTRL, 32'h9);
    checkOutput("s1_ctrl_wr", Dout, 32'h9);
    idleTicks(2, T_COUNT);
    for (int v = 5; v >= 0; v--) begin
      checkOutput($sformatf("s1_count%0d", v), Dout, v);
      if (v > 0) applyStimulus(1'b0, T_COUNT, 32'd0);
    end
    checkOutput("s1_irq_int", {31'd0, IRQ}, 32'd1);
    applyStimulus(1'b0, T_CTRL, 32'd0);
    checkOutput("s1_ctrl_after", Dout, 32'h8);
    checkOutput("s1_irq_idle", {31'd0, IRQ}, 32'd1);
    idleTicks(2, T_CTRL);
    checkOutput("s1_irq_held", {31'd0, IRQ}, 32'd1);

    // PRESET write drops IRQ but leaves COUNT alone until the next load.
    applyStimulus(1'b1, T_PRESET, 32'd2);
    checkOutput("s2_irq_drop", {31'd0, IRQ}, 32'd0);
    readAt(T_COUNT);  checkOutput("s2_count_kept", Dout, 32'd0);
    readAt(T_PRESET); checkOutput("s2_preset", Dout, 32'd2);
    applyStimulus(1'b1, T_CTRL, 32'h9);
    idleTicks(2, T_COUNT);
    checkOutput("s2_count_load", Dout, 32'd2);
    idleTicks(2, T_COUNT);
    checkOutput("s2_count_end", Dout, 32'd0);
    checkOutput("s2_irq", {31'd0, IRQ}, 32'd1);

    // Auto-reload: period PRESET+3 = 6, one-cycle pulses.
    doReset();
    applyStimulus(1'b1, T_PRESET, 32'd3);
    applyStimulus(1'b1, T_CTRL, 32'hB);
    highs = 0; first_hi = -1; last_hi = -1; count8 = '0;
    for (int t = 1; t <= 24; t++) begin
      applyStimulus(1'b0, T_COUNT, 32'd0);
      if (IRQ === 1'b1) begin
        highs++;
        if (first_hi < 0) first_hi = t;
        last_hi = t;
      end
      if (t == 8) count8 = Dout;
    end
    checkOutput("s3_pulses", highs, 32'd4);
    checkOutput("s3_first", first_hi, 32'd5);
    checkOutput("s3_last", last_hi, 32'd23);
    checkOutput("s3_reload", count8, 32'd3);

    // Masked expiry: flag sets silently, CTRL write clears it before unmasking.
    doReset();
    applyStimulus(1'b1, T_PRESET, 32'd4);
    applyStimulus(1'b1, T_CTRL, 32'h1);
    irq_seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      applyStimulus(1'b0, T_COUNT, 32'd0);
      if (IRQ !== 1'b0) irq_seen = 1'b1;
    end
    checkOutput("s4_masked", {31'd0, irq_seen}, 32'd0);
    readAt(T_CTRL); checkOutput("s4_ctrl", Dout, 32'h0);
    applyStimulus(1'b1, T_CTRL, 32'h8);
    irq_seen = 1'b0;
    for (int t = 0; t < 3; t++) begin
      applyStimulus(1'b0, T_CTRL, 32'd0);
      if (IRQ !== 1'b0) irq_seen = 1'b1;
    end
    checkOutput("s4_unmask", {31'd0, irq_seen}, 32'd0);

    // Stop mid-count, then restart and reload.
    doReset();
    applyStimulus(1'b1, T_PRESET, 32'd20);
    applyStimulus(1'b1, T_CTRL, 32'h1);
    idleTicks(14, T_COUNT);
    checkOutput("s5_count8", Dout, 32'd8);
    applyStimulus(1'b1, T_CTRL, 32'h0);
    idleTicks(1, T_COUNT);
    checkOutput("s5_hold", Dout, 32'd7);
    idleTicks(3, T_COUNT);
    checkOutput("s5_hold_late", Dout, 32'd7);
    applyStimulus(1'b1, T_CTRL, 32'h1);
    idleTicks(1, T_COUNT);
    checkOutput("s5_load_cycle", Dout, 32'd7);
    idleTicks(1, T_COUNT);
    checkOutput("s5_reloaded", Dout, 32'd20);

    // Reset mid-count overrides a simultaneous COUNT write.
    doReset();
    applyStimulus(1'b1, T_PRESET, 32'd30);
    applyStimulus(1'b1, T_CTRL, 32'h9);
    idleTicks(22, T_COUNT);
    checkOutput("s6_count10", Dout, 32'd10);
    reset = 1'b1;
    applyStimulus(1'b1, T_COUNT, 32'hDEAD);
    reset = 1'b0;
    checkOutput("s6_irq", {31'd0, IRQ}, 32'd0);
    checkOutput("s6_count", Dout, 32'd0);
    readAt(T_CTRL);   checkOutput("s6_ctrl", Dout, 32'd0);
    readAt(T_PRESET); checkOutput("s6_preset", Dout, 32'd0);
    applyStimulus(1'b1, T_COUNT, 32'h55);
    checkOutput("s6_count_ro", Dout, 32'd0);
    applyStimulus(1'b1, T_NONE, 32'hFFFF_FFFF);
    checkOutput("s6_off3", Dout, 32'd0);
    applyStimulus(1'b1, T_CTRL, 32'hFFFF_FFF0);
    checkOutput("s6_ctrl_hi", Dout, 32'd0);

    // PRESET=0 expires after one count cycle; CTRL write beats the INT enable clear.
    doReset();
    applyStimulus(1'b1, T_PRESET, 32'd0);
    applyStimulus(1'b1, T_CTRL, 32'h9);
    idleTicks(2, T_CTRL);
    checkOutput("s7_irq_cnt", {31'd0, IRQ}, 32'd0);
    idleTicks(1, T_CTRL);
    checkOutput("s7_irq_int", {31'd0, IRQ}, 32'd1);
    applyStimulus(1'b1, T_CTRL, 32'h9);
    checkOutput("s7_ctrl_kept", Dout, 32'h9);
    checkOutput("s7_irq_clr", {31'd0, IRQ}, 32'd0);
    idleTicks(2, T_CTRL);
    checkOutput("s7_irq_again0", {31'd0, IRQ}, 32'd0);
    idleTicks(1, T_CTRL);
    checkOutput("s7_irq_again1", {31'd0, IRQ}, 32'd1);

    // Mode 10 behaves as one-shot.
    doReset();
    applyStimulus(1'b1, T_PRESET, 32'd1);
    applyStimulus(1'b1, T_CTRL, 32'hD);
    idleTicks(4, T_CTRL);
    checkOutput("s8_ctrl", Dout, 32'hC);
    checkOutput("s8_irq", {31'd0, IRQ}, 32'd1);
    idleTicks(2, T_COUNT);
    checkOutput("s8_count", Dout, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
